// File: rtl/pi_loop_sequencer.sv
// Start/stop, soft-start ramp, bumpless PI handoff, setpoint keys and fault latch for the resonant converter.
// Optional ADC watchdog (and its WDOG_CYC parameter) is built only when SEQ_WDOG_EN is defined.
module pi_loop_sequencer #(
    parameter int CNT_MAX      = 625,
    parameter int CNT_MIN      = 416,
    parameter int RAMP_DIV     = 50,
    parameter int VO_GOAL_DEF  = 3430,
    parameter int VO_GOAL_MAX  = 4000,
    parameter int VO_GOAL_MIN  = 2000,
    parameter int VO_STEP      = 5,
    parameter int HANDOFF_BAND = 64,
    parameter int VO_OVP       = 4050
`ifdef SEQ_WDOG_EN
    ,
    parameter int WDOG_CYC     = 1000
`endif
) (
    input  logic               clk,
    input  logic               rstp,
    input  logic               start,
    input  logic               stop,
    input  logic               fault_clr,
    input  logic               key_add,
    input  logic               key_sub,
    input  logic               adc_valid,
    input  logic signed [12:0] vo,
    input  logic        [11:0] pi_cnt,
    output logic signed [12:0] vo_goal,
    output logic               pi_en,
    output logic               pi_preset,
    output logic        [11:0] preset_cnt,
    output logic        [11:0] freq_cnt,
    output logic               drv_en,
    output logic        [1:0]  state,
    output logic        [1:0]  fault_code
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SOFT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVP  = 2'b01;

    localparam int DIV_W = $clog2(RAMP_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

    localparam logic        [11:0] CNT_MAX_C  = 12'(CNT_MAX);
    localparam logic        [11:0] CNT_MIN_C  = 12'(CNT_MIN);
    localparam logic signed [12:0] GOAL_DEF_C = 13'(VO_GOAL_DEF);
    localparam logic signed [13:0] GOAL_MAX_C = 14'(VO_GOAL_MAX);
    localparam logic signed [13:0] GOAL_MIN_C = 14'(VO_GOAL_MIN);
    localparam logic signed [13:0] STEP_C     = 14'(VO_STEP);
    localparam logic signed [13:0] BAND_C     = 14'(HANDOFF_BAND);
    localparam logic signed [13:0] OVP_C      = 14'(VO_OVP);

    state_t                state_q, state_d;
    logic        [1:0]     fault_code_q, fault_code_d;
    logic signed [12:0]    vo_goal_q, vo_goal_d;
    logic        [11:0]    freq_cnt_q, freq_cnt_d;
    logic        [DIV_W-1:0] div_q, div_d;
    logic                  key_add_q, key_sub_q;

    logic                  add_edge, sub_edge;
    logic signed [13:0]    vo_ext, goal_ext, goal_up, goal_dn;
    logic                  active, ovp_trip, handoff, wdog_trip;
    logic        [11:0]    pi_cnt_clamped;

    assign add_edge = key_add & ~key_add_q;
    assign sub_edge = key_sub & ~key_sub_q;

    // Both operands widened to 14 bits so the goal-minus-band threshold cannot wrap.
    assign vo_ext   = {vo[12], vo};
    assign goal_ext = {vo_goal_q[12], vo_goal_q};
    assign goal_up  = goal_ext + STEP_C;
    assign goal_dn  = goal_ext - STEP_C;

    assign active   = (state_q == ST_SOFT) || (state_q == ST_RUN);
    assign ovp_trip = active && adc_valid && (vo_ext >= OVP_C);
    assign handoff  = adc_valid && (vo_ext >= (goal_ext - BAND_C));

    always_comb begin
        pi_cnt_clamped = pi_cnt;
        if (pi_cnt > CNT_MAX_C) begin
            pi_cnt_clamped = CNT_MAX_C;
        end else if (pi_cnt < CNT_MIN_C) begin
            pi_cnt_clamped = CNT_MIN_C;
        end
    end

`ifdef SEQ_WDOG_EN
    localparam logic [1:0]  FC_WDOG = 2'b10;
    localparam logic [15:0] WDOG_C  = 16'(WDOG_CYC);

    logic [15:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d = wdog_q;
        if (adc_valid || !active) begin
            wdog_d = '0;
        end else if (wdog_q != 16'hFFFF) begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstp) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign wdog_trip = active && (wdog_q >= WDOG_C);
`else
    assign wdog_trip = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rstp) begin
            state_q      <= ST_IDLE;
            fault_code_q <= FC_NONE;
        end else begin
            state_q      <= state_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Next-state logic: fault beats stop, stop beats handoff/ramp.
    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SOFT;
                end
            end
            ST_SOFT, ST_RUN: begin
                if (ovp_trip) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FC_OVP;
                end else if (wdog_trip) begin
`ifdef SEQ_WDOG_EN
                    state_d      = ST_FAULT;
                    fault_code_d = FC_WDOG;
`endif
                end else if (stop) begin
                    state_d = ST_IDLE;
                end else if ((state_q == ST_SOFT) && (handoff || (freq_cnt_q == CNT_MAX_C))) begin
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !start) begin
                    state_d      = ST_IDLE;
                    fault_code_d = FC_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        drv_en    = 1'b0;
        pi_en     = 1'b0;
        pi_preset = 1'b1;
        case (state_q)
            ST_SOFT: begin
                drv_en = 1'b1;
            end
            ST_RUN: begin
                drv_en    = 1'b1;
                pi_en     = 1'b1;
                pi_preset = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // The RUN update uses pi_cnt registered, so the first RUN cycle still shows the ramp value.
    always_comb begin
        div_d      = '0;
        freq_cnt_d = CNT_MIN_C;
        case (state_q)
            ST_SOFT: begin
                freq_cnt_d = freq_cnt_q;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (freq_cnt_q < CNT_MAX_C) begin
                        freq_cnt_d = freq_cnt_q + 12'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_RUN: begin
                freq_cnt_d = pi_cnt_clamped;
            end
            default: begin
            end
        endcase
        if ((state_d == ST_IDLE) || (state_d == ST_FAULT)) begin
            div_d      = '0;
            freq_cnt_d = CNT_MIN_C;
        end
    end

    always_comb begin
        vo_goal_d = vo_goal_q;
        if (add_edge && !sub_edge) begin
            vo_goal_d = (goal_up > GOAL_MAX_C) ? GOAL_MAX_C[12:0] : goal_up[12:0];
        end else if (sub_edge && !add_edge) begin
            vo_goal_d = (goal_dn < GOAL_MIN_C) ? GOAL_MIN_C[12:0] : goal_dn[12:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rstp) begin
            vo_goal_q  <= GOAL_DEF_C;
            freq_cnt_q <= CNT_MIN_C;
            div_q      <= '0;
            key_add_q  <= 1'b0;
            key_sub_q  <= 1'b0;
        end else begin
            vo_goal_q  <= vo_goal_d;
            freq_cnt_q <= freq_cnt_d;
            div_q      <= div_d;
            key_add_q  <= key_add;
            key_sub_q  <= key_sub;
        end
    end

    assign vo_goal    = vo_goal_q;
    assign freq_cnt   = freq_cnt_q;
    assign preset_cnt = freq_cnt_q;
    assign state      = state_q;
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_pi_loop_sequencer.sv
// Directed bench for pi_loop_sequencer: setpoint keys, soft-start ramp, handoff, clamp, faults, reset.
module tb_pi_loop_sequencer;

    logic               clk = 1'b0;
    logic               rstp = 1'b1;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               fault_clr = 1'b0;
    logic               key_add = 1'b0;
    logic               key_sub = 1'b0;
    logic               adc_valid = 1'b0;
    logic signed [12:0] vo = '0;
    logic        [11:0] pi_cnt = '0;
    logic signed [12:0] vo_goal;
    logic               pi_en;
    logic               pi_preset;
    logic        [11:0] preset_cnt;
    logic        [11:0] freq_cnt;
    logic               drv_en;
    logic        [1:0]  state;
    logic        [1:0]  fault_code;

    int checks = 0;
    int errors = 0;

    pi_loop_sequencer dut (
        .clk        (clk),
        .rstp       (rstp),
        .start      (start),
        .stop       (stop),
        .fault_clr  (fault_clr),
        .key_add    (key_add),
        .key_sub    (key_sub),
        .adc_valid  (adc_valid),
        .vo         (vo),
        .pi_cnt     (pi_cnt),
        .vo_goal    (vo_goal),
        .pi_en      (pi_en),
        .pi_preset  (pi_preset),
        .preset_cnt (preset_cnt),
        .freq_cnt   (freq_cnt),
        .drv_en     (drv_en),
        .state      (state),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_state"},      32'(state),      0);
        chk({pfx, "_vo_goal"},    32'(vo_goal),    3430);
        chk({pfx, "_freq_cnt"},   32'(freq_cnt),   416);
        chk({pfx, "_preset_cnt"}, 32'(preset_cnt), 416);
        chk({pfx, "_pi_en"},      32'(pi_en),      0);
        chk({pfx, "_pi_preset"},  32'(pi_preset),  1);
        chk({pfx, "_drv_en"},     32'(drv_en),     0);
        chk({pfx, "_fault_code"}, 32'(fault_code), 0);
    endtask

    task automatic press_add;
        key_add = 1'b1;
        tick;
        key_add = 1'b0;
        tick;
    endtask

    task automatic press_sub;
        key_sub = 1'b1;
        tick;
        key_sub = 1'b0;
        tick;
    endtask

    task automatic do_reset;
        rstp = 1'b1;
        tick;
        rstp = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        logic [11:0] prev;

        // Reset state
        tick;
        tick;
        chk_reset("rst");
        rstp = 1'b0;

        // Setpoint stepping
        press_add;
        chk("goal_add1", 32'(vo_goal), 3435);
        press_add;
        press_add;
        press_sub;
        chk("goal_3add_1sub", 32'(vo_goal), 3440);
        key_add = 1'b1;
        for (int i = 0; i < 20; i++) tick;
        key_add = 1'b0;
        tick;
        chk("goal_hold_one_step", 32'(vo_goal), 3445);
        key_add = 1'b1;
        key_sub = 1'b1;
        tick;
        key_add = 1'b0;
        key_sub = 1'b0;
        tick;
        chk("goal_both_edges", 32'(vo_goal), 3445);
        for (int i = 0; i < 111; i++) press_add;
        chk("goal_reach_max", 32'(vo_goal), 4000);
        press_add;
        chk("goal_sat_max", 32'(vo_goal), 4000);
        for (int i = 0; i < 400; i++) press_sub;
        chk("goal_reach_min", 32'(vo_goal), 2000);
        press_sub;
        chk("goal_sat_min", 32'(vo_goal), 2000);

        // Soft-start ramp all the way to CNT_MAX
        do_reset;
        chk("goal_after_reset", 32'(vo_goal), 3430);
        pi_cnt = 12'd625;
        vo = '0;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("soft_state", 32'(state), 1);
        chk("soft_drv_en", 32'(drv_en), 1);
        chk("soft_pi_en", 32'(pi_en), 0);
        chk("soft_pi_preset", 32'(pi_preset), 1);
        chk("soft_freq_start", 32'(freq_cnt), 416);
        n = 0;
        bad = 0;
        prev = freq_cnt;
        while (state != 2'd2 && n < 12000) begin
            adc_valid = (n % 10 == 0);
            tick;
            n++;
            if (n == 49)  chk("ramp_n49",  32'(freq_cnt), 416);
            if (n == 50)  chk("ramp_n50",  32'(freq_cnt), 417);
            if (n == 100) chk("ramp_n100", 32'(freq_cnt), 418);
            if (freq_cnt != prev && freq_cnt != prev + 12'd1) bad++;
            prev = freq_cnt;
        end
        adc_valid = 1'b0;
        chk("ramp_run_cycle", 32'(n), 10451);
        chk("ramp_monotonic", 32'(bad), 0);
        chk("ramp_run_freq", 32'(freq_cnt), 625);
        chk("ramp_run_pi_en", 32'(pi_en), 1);
        tick;
        chk("ramp_run_freq_hold", 32'(freq_cnt), 625);

        // Handoff at the band boundary, then PI clamp
        do_reset;
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (freq_cnt != 12'd500 && n < 6000) begin
            adc_valid = (n % 10 == 0);
            tick;
            n++;
        end
        chk("soft_reach_500_cycle", 32'(n), 4200);
        adc_valid = 1'b1;
        vo = 13'sd3365;
        tick;
        chk("handoff_below_band", 32'(state), 1);
        vo = 13'sd3366;
        tick;
        adc_valid = 1'b0;
        chk("handoff_state", 32'(state), 2);
        chk("handoff_bumpless", 32'(freq_cnt), 500);
        chk("handoff_pi_preset", 32'(pi_preset), 0);
        pi_cnt = 12'd700;
        tick;
        chk("clamp_high", 32'(freq_cnt), 625);
        pi_cnt = 12'd300;
        tick;
        chk("clamp_low", 32'(freq_cnt), 416);
        pi_cnt = 12'd520;
        tick;
        chk("pi_pass", 32'(freq_cnt), 520);
        chk("preset_follows", 32'(preset_cnt), 520);

        // OVP threshold, priority over stop, and fault clear rules
        adc_valid = 1'b1;
        vo = 13'sd4049;
        tick;
        chk("ovp_below", 32'(state), 2);
        vo = 13'sd4050;
        stop = 1'b1;
        tick;
        adc_valid = 1'b0;
        stop = 1'b0;
        vo = '0;
        chk("ovp_state", 32'(state), 3);
        chk("ovp_code", 32'(fault_code), 1);
        chk("ovp_drv_en", 32'(drv_en), 0);
        chk("ovp_freq", 32'(freq_cnt), 416);
        fault_clr = 1'b1;
        start = 1'b1;
        tick;
        chk("fault_no_restart", 32'(state), 3);
        chk("fault_code_held", 32'(fault_code), 1);
        start = 1'b0;
        tick;
        fault_clr = 1'b0;
        chk("fault_clr_state", 32'(state), 0);
        chk("fault_clr_code", 32'(fault_code), 0);

        // Stop from RUN
        start = 1'b1;
        tick;
        start = 1'b0;
        adc_valid = 1'b1;
        vo = 13'sd3400;
        tick;
        adc_valid = 1'b0;
        chk("run2_state", 32'(state), 2);
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("stop_state", 32'(state), 0);
        chk("stop_drv_en", 32'(drv_en), 0);
        chk("stop_freq", 32'(freq_cnt), 416);

        // ADC silence in RUN
        start = 1'b1;
        tick;
        start = 1'b0;
        adc_valid = 1'b1;
        tick;
        adc_valid = 1'b0;
        chk("run3_state", 32'(state), 2);
        n = 0;
        while (state != 2'd3 && n < 1100) begin
            tick;
            n++;
        end
`ifdef SEQ_WDOG_EN
        chk("wdog_cycle", 32'(n), 1001);
        chk("wdog_code", 32'(fault_code), 2);
        chk("wdog_drv_en", 32'(drv_en), 0);
`else
        chk("nowdog_state", 32'(state), 2);
        chk("nowdog_code", 32'(fault_code), 0);
`endif
        fault_clr = 1'b1;
        stop = 1'b1;
        tick;
        fault_clr = 1'b0;
        stop = 1'b0;
        chk("back_idle", 32'(state), 0);

        // Stop in SOFT, then reset mid-SOFT
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick;
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("stop_soft_state", 32'(state), 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        press_add;
        for (int i = 0; i < 120; i++) tick;
        chk("midsoft_state", 32'(state), 1);
        chk("midsoft_goal", 32'(vo_goal), 3435);
        chk("midsoft_freq", 32'(freq_cnt), 418);
        rstp = 1'b1;
        tick;
        chk_reset("midsoft_rst");
        rstp = 1'b0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
